instr_readback_checker: RTL and testbench



---
 rtl/instr_readback_checker.sv | 158 +++++++++++++++
 tb/tb_instr_readback_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_readback_checker.sv
// Sweeps the instruction register over an address range, recomputes each result
// from opcode/operands and streams address, word and pass/fail over valid/ready.
module instr_readback_checker #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned OP_W   = 32,
  parameter int unsigned RES_W  = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_ptr,
  input  logic [ADDR_W-1:0] last_ptr,
  output logic [ADDR_W-1:0] read_pointer,
  input  logic [3:0]        iw_opc,
  input  logic [OP_W-1:0]   iw_op_a,
  input  logic [OP_W-1:0]   iw_op_b,
  input  logic [RES_W-1:0]  iw_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [3:0]        out_opc,
  output logic [RES_W-1:0]  out_res,
  output logic [RES_W-1:0]  out_exp,
  output logic              out_mismatch,
  output logic              out_div0,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  chk_count,
  output logic [CNT_W-1:0]  err_count
);

  // ZERO, PASSA, PASSB and codes 8..15 all expect 0
  localparam logic [3:0] OPC_ADD  = 4'd3;
  localparam logic [3:0] OPC_SUB  = 4'd4;
  localparam logic [3:0] OPC_MULT = 4'd5;
  localparam logic [3:0] OPC_DIV  = 4'd6;
  localparam logic [3:0] OPC_MOD  = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_OUT,
    S_FIN
  } state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] last_q;
  logic              hs_c;
  logic              last_c;
  logic              div0_c;
  logic signed [RES_W-1:0] a_ext, b_ext, exp_c;

  assign last_c = (ptr == last_q);

  // Expected result from the live register word; sampled on the CAPTURE edge
  always_comb begin
    a_ext  = {{(RES_W-OP_W){iw_op_a[OP_W-1]}}, iw_op_a};
    b_ext  = {{(RES_W-OP_W){iw_op_b[OP_W-1]}}, iw_op_b};
    exp_c  = '0;
    div0_c = 1'b0;
    case (iw_opc)
      OPC_ADD:  exp_c = a_ext + b_ext;
      OPC_SUB:  exp_c = a_ext - b_ext;
      OPC_MULT: exp_c = a_ext * b_ext;
      OPC_DIV: begin
        if (b_ext == '0) div0_c = 1'b1;
        else             exp_c  = a_ext / b_ext;
      end
      OPC_MOD: begin
        if (b_ext == '0) div0_c = 1'b1;
        else             exp_c  = a_ext % b_ext;
      end
      default: exp_c = '0;
    endcase
  end

  // Next-state logic; abort overrides the handshake
  always_comb begin
    next_state = state;
    hs_c       = 1'b0;
    case (state)
      S_IDLE:    if (start) next_state = S_FETCH;
      S_FETCH:   next_state = S_CAPTURE;
      S_CAPTURE: next_state = S_OUT;
      S_OUT: begin
        if (out_ready) begin
          hs_c       = 1'b1;
          next_state = last_c ? S_FIN : S_FETCH;
        end
      end
      S_FIN:     next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) begin
      next_state = S_IDLE;
      hs_c       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Datapath, record and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr          <= '0;
      last_q       <= '0;
      read_pointer <= '0;
      out_valid    <= 1'b0;
      out_addr     <= '0;
      out_opc      <= '0;
      out_res      <= '0;
      out_exp      <= '0;
      out_mismatch <= 1'b0;
      out_div0     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      chk_count    <= '0;
      err_count    <= '0;
    end else begin
      busy      <= (next_state != S_IDLE);
      out_valid <= (next_state == S_OUT);
      done      <= (next_state == S_FIN);

      if ((state == S_IDLE) && start) begin
        ptr       <= first_ptr;
        last_q    <= last_ptr;
        chk_count <= '0;
        err_count <= '0;
      end

      if (state == S_FETCH) read_pointer <= ptr;

      if ((state == S_CAPTURE) && !abort) begin
        out_addr     <= ptr;
        out_opc      <= iw_opc;
        out_res      <= iw_res;
        out_exp      <= exp_c;
        out_div0     <= div0_c;
        out_mismatch <= (iw_res != exp_c) && !div0_c;
      end

      if (hs_c) begin
        if (chk_count != '1) chk_count <= chk_count + CNT_W'(1);
        if (out_mismatch && (err_count != '1)) err_count <= err_count + CNT_W'(1);
        if (!last_c) ptr <= ptr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_readback_checker.sv
// Directed and randomized sweeps of instr_readback_checker against an
// arithmetic reference model of the instruction register contents.
module tb_instr_readback_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort, out_ready;
  logic [4:0]  first_ptr, last_ptr, read_pointer, out_addr;
  logic [3:0]  iw_opc, out_opc;
  logic [31:0] iw_op_a, iw_op_b;
  logic [63:0] iw_res, out_res, out_exp;
  logic        out_valid, out_mismatch, out_div0, busy, done;
  logic [15:0] chk_count, err_count;

  logic [3:0]  m_opc [32];
  logic [31:0] m_a   [32];
  logic [31:0] m_b   [32];
  logic [63:0] m_res [32];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instruction register model: combinational read
  assign iw_opc  = m_opc[read_pointer];
  assign iw_op_a = m_a[read_pointer];
  assign iw_op_b = m_b[read_pointer];
  assign iw_res  = m_res[read_pointer];

  instr_readback_checker dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .first_ptr(first_ptr), .last_ptr(last_ptr), .read_pointer(read_pointer),
    .iw_opc(iw_opc), .iw_op_a(iw_op_a), .iw_op_b(iw_op_b), .iw_res(iw_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_opc(out_opc), .out_res(out_res), .out_exp(out_exp),
    .out_mismatch(out_mismatch), .out_div0(out_div0), .busy(busy), .done(done),
    .chk_count(chk_count), .err_count(err_count)
  );

  function automatic logic [63:0] ref_exp(input logic [3:0] opc, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (opc)
      4'd3: return 64'(sa + sb);
      4'd4: return 64'(sa - sb);
      4'd5: return 64'(sa * sb);
      4'd6: return (sb == 0) ? 64'd0 : 64'(sa / sb);
      4'd7: return (sb == 0) ? 64'd0 : 64'(sa % sb);
      default: return 64'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic put(input int idx, input logic [3:0] opc, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] res);
    m_opc[idx] = opc; m_a[idx] = a; m_b[idx] = b; m_res[idx] = res;
  endtask

  task automatic check_rec(input string pfx, input logic [4:0] addr, input logic [63:0] e,
                           input logic mm, input logic d0);
    check({pfx, "_valid"}, out_valid, 1'b1);
    check({pfx, "_addr"}, out_addr, addr);
    check({pfx, "_opc"}, out_opc, m_opc[addr]);
    check({pfx, "_res"}, out_res, m_res[addr]);
    check({pfx, "_exp"}, out_exp, e);
    check({pfx, "_mismatch"}, out_mismatch, mm);
    check({pfx, "_div0"}, out_div0, d0);
  endtask

  // One sweep first..last; stall cycles per record, optional abort on record abort_rec
  task automatic sweep(input logic [4:0] first, input logic [4:0] last, input int stall,
                       input int abort_rec, input bit poke_start);
    int n_rec, n, cyc, exp_chk, exp_err;
    logic [4:0]  addr;
    logic [63:0] e;
    logic mm, d0, seen_done;
    n_rec = ((int'(last) - int'(first)) & 31) + 1;
    out_ready = (stall == 0);
    first_ptr = first; last_ptr = last; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 0; exp_chk = 0; exp_err = 0;
    check("start_chk_clear", chk_count, 0);
    check("start_err_clear", err_count, 0);
    check("start_busy", busy, 1'b1);
    for (int k = 0; k < n_rec; k++) begin
      addr = first + 5'(k);
      e  = ref_exp(m_opc[addr], m_a[addr], m_b[addr]);
      d0 = ((m_opc[addr] == 4'd6) || (m_opc[addr] == 4'd7)) && (m_b[addr] == 32'd0);
      mm = (m_res[addr] != e) && !d0;
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; cyc++; end
      check("rec_latency", 64'(n), 64'd2);
      if (n >= 20) return;
      check_rec("rec", addr, e, mm, d0);
      if (stall > 0) begin
        for (int s = 0; s < stall; s++) begin
          start = poke_start && (s == 0);
          if (start) begin first_ptr = 5'd5; last_ptr = 5'd5; end
          @(negedge clk); cyc++;
        end
        start = 1'b0;
        check_rec("stall", addr, e, mm, d0);
      end
      if (k == abort_rec) begin
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        check("abort_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_chk", chk_count, 64'(exp_chk));
        check("abort_err", err_count, 64'(exp_err));
        seen_done = done;
        repeat (4) begin @(negedge clk); seen_done |= done; end
        check("abort_no_done", seen_done, 1'b0);
        check("abort_chk_hold", chk_count, 64'(exp_chk));
        return;
      end
      out_ready = 1'b1;
      @(negedge clk); cyc++;
      exp_chk++;
      if (mm) exp_err++;
      if (stall > 0) out_ready = 1'b0;
      check("hs_chk", chk_count, 64'(exp_chk));
      check("hs_err", err_count, 64'(exp_err));
    end
    check("done_pulse", done, 1'b1);
    check("done_valid_low", out_valid, 1'b0);
    if (stall == 0) check("sweep_cycles", 64'(cyc), 64'(3 * n_rec));
    @(negedge clk);
    check("done_cleared", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("final_chk", chk_count, 64'(exp_chk));
    check("final_err", err_count, 64'(exp_err));
  endtask

  initial begin
    logic [3:0]  opc;
    logic [31:0] a, b;
    logic [63:0] r;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    first_ptr = '0; last_ptr = '0;
    for (int i = 0; i < 32; i++) put(i, 4'd0, 32'd0, 32'd0, 64'd0);
    #12;
    check("rst_read_pointer", read_pointer, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_chk", chk_count, 0);
    check("rst_err", err_count, 0);
    check("rst_exp", out_exp, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single ADD record
    put(0, 4'd3, 32'd5, -32'sd3, 64'd2);
    sweep(5'd0, 5'd0, 0, -1, 1'b0);

    // Full sweep of correct mixed arithmetic
    for (int i = 0; i < 32; i++) begin
      opc = 4'($urandom_range(3, 7));
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 100)) : $urandom;
      if (b == 0) b = 32'd1;
      put(i, opc, a, b, ref_exp(opc, a, b));
    end
    put(3, 4'd5, 32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE);
    put(4, 4'd6, -32'sd7, 32'd2, -64'sd3);
    put(5, 4'd7, -32'sd7, 32'd2, -64'sd1);
    put(6, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    sweep(5'd0, 5'd31, 0, -1, 1'b0);

    // Randomized contents with undefined codes, zero divisors and corrupted results
    for (int i = 0; i < 32; i++) begin
      opc = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      r = ref_exp(opc, a, b);
      if ($urandom_range(0, 3) == 0) r = r ^ (64'd1 << $urandom_range(0, 63));
      put(i, opc, a, b, r);
    end
    sweep(5'd0, 5'd31, 0, -1, 1'b0);

    // Wrong stored result: SUB 10-4 stored as 0
    put(7, 4'd4, 32'd10, 32'd4, 64'd0);
    sweep(5'd7, 5'd7, 0, -1, 1'b0);

    // Wrapping sweep with stalls and an ignored start while busy
    for (int i = 0; i < 32; i++) begin
      opc = 4'($urandom_range(3, 7));
      a = $urandom; b = $urandom;
      put(i, opc, a, b, ref_exp(opc, a, b));
    end
    sweep(5'd30, 5'd1, 5, -1, 1'b1);

    // Divide by zero skips the comparison
    put(9, 4'd6, 32'd9, 32'd0, 64'd123);
    sweep(5'd9, 5'd9, 0, -1, 1'b0);
    put(9, 4'd7, -32'sd9, 32'd0, 64'd0);
    sweep(5'd9, 5'd9, 2, -1, 1'b0);

    // Abort during the stall of record 2 of 4, then a fresh start
    sweep(5'd10, 5'd13, 3, 1, 1'b0);
    sweep(5'd10, 5'd10, 0, -1, 1'b0);

    // Asynchronous reset mid-sweep
    out_ready = 1'b1; first_ptr = 5'd0; last_ptr = 5'd31; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_chk", chk_count, 0);
    check("midrst_read_pointer", read_pointer, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
